// File: rtl/chess_display_pkg.sv
// Shared display types and constants for the chess board LCD path.
// Used by the region scheduler and its bounds decoder.
package chess_display_pkg;

    localparam int LCD_WIDTH     = 240;
    localparam int LCD_HEIGHT    = 320;
    localparam int BANNER_HEIGHT = 40;
    localparam int SQUARE_SIZE   = 30;

    typedef enum logic [1:0] {
        REG_FULL,
        REG_TOP,
        REG_BOT,
        REG_SQ
    } regionSel_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef struct packed {
        logic [7:0] x0;
        logic [7:0] x1;
        logic [8:0] y0;
        logic [8:0] y1;
    } regionBounds_t;

endpackage

// File: rtl/lcd_region_decode.sv
// Maps a region select (and square index) to inclusive pixel bounds.
// Squares sit below the top banner: x0 = 30*col, y0 = 40 + 30*row.
module lcd_region_decode
    import chess_display_pkg::*;
(
    input  regionSel_t    regionSel,
    input  logic [5:0]    squareIdx,
    output regionBounds_t bounds
);

    logic [7:0] sqX0;
    logic [8:0] sqY0;

    assign sqX0 = 8'(SQUARE_SIZE) * {5'd0, squareIdx[2:0]};
    assign sqY0 = 9'(BANNER_HEIGHT) + 9'(SQUARE_SIZE) * {6'd0, squareIdx[5:3]};

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        bounds.x0 = '0;
        bounds.x1 = 8'(LCD_WIDTH - 1);
        bounds.y0 = '0;
        bounds.y1 = 9'(LCD_HEIGHT - 1);
        case (regionSel)
            REG_TOP: bounds.y1 = 9'(BANNER_HEIGHT - 1);
            REG_BOT: bounds.y0 = 9'(LCD_HEIGHT - BANNER_HEIGHT);
            REG_SQ: begin
                bounds.x0 = sqX0;
                bounds.x1 = sqX0 + 8'(SQUARE_SIZE - 1);
                bounds.y0 = sqY0;
                bounds.y1 = sqY0 + 9'(SQUARE_SIZE - 1);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_region_scheduler.sv
// Shares the LT24 pixel port among full-frame, banner and square redraws:
// latches requests, picks one region by fixed priority and raster-scans it.
module lcd_region_scheduler
    import chess_display_pkg::*;
(
    input  logic        clock,
    input  logic        resetApp,
    input  logic        fullReq,
    input  logic [1:0]  bannerReq,
    input  logic        squareReq,
    input  logic [5:0]  squareIdx,
    input  logic [15:0] pixelIn,
    input  logic        pixelReady,
    output logic [7:0]  scanX,
    output logic [8:0]  scanY,
    output logic [7:0]  xAddr,
    output logic [8:0]  yAddr,
    output logic [15:0] pixelData,
    output logic        pixelWrite,
    output logic        busy,
    output logic        regionDone
);

    state_t        state, stateNext;
    logic          fullPend;
    logic [1:0]    bannerPend;
    logic [63:0]   squarePend;
    regionSel_t    curSel, nextSel, decSel;
    logic [5:0]    curSq, nextSq, decSq;
    logic          anyPend, lastLoaded;
    logic          selectNow, loadNow, doneNow;
    logic          fullClr;
    logic [1:0]    bannerClr;
    logic [63:0]   squareClr;
    regionBounds_t bounds;

    assign anyPend = fullPend | (|bannerPend) | (|squarePend);
    assign busy    = (state == RUN);

    // Scanning downward leaves the lowest pending square index selected.
    always_comb begin
        nextSq = '0;
        for (int i = 63; i >= 0; i--) begin
            if (squarePend[i]) nextSq = 6'(i);
        end
        if (fullPend)           nextSel = REG_FULL;
        else if (bannerPend[0]) nextSel = REG_TOP;
        else if (bannerPend[1]) nextSel = REG_BOT;
        else                    nextSel = REG_SQ;
    end

    // The decoder supplies the origin of the region being chosen while idle,
    // and the bounds of the active region while scanning.
    assign decSel = (state == IDLE) ? nextSel : curSel;
    assign decSq  = (state == IDLE) ? nextSq  : curSq;

    lcd_region_decode uDecode (
        .regionSel (decSel),
        .squareIdx (decSq),
        .bounds    (bounds)
    );

    always_comb begin
        stateNext = state;
        selectNow = 1'b0;
        loadNow   = 1'b0;
        doneNow   = 1'b0;
        case (state)
            IDLE: if (anyPend) begin
                selectNow = 1'b1;
                stateNext = RUN;
            end
            RUN: begin
                if (lastLoaded) begin
                    if (pixelWrite && pixelReady) begin
                        doneNow   = 1'b1;
                        stateNext = IDLE;
                    end
                end else if (!pixelWrite || pixelReady) begin
                    loadNow = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        fullClr   = selectNow && (nextSel == REG_FULL);
        bannerClr = '0;
        squareClr = '0;
        if (selectNow) begin
            case (nextSel)
                REG_FULL: begin
                    bannerClr = '1;
                    squareClr = '1;
                end
                REG_TOP: bannerClr[0] = 1'b1;
                REG_BOT: bannerClr[1] = 1'b1;
                default: squareClr = 64'd1 << nextSq;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) state <= IDLE;
        else          state <= stateNext;
    end

    // Set is applied after clear so a request arriving on its own selection cycle survives.
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            fullPend   <= 1'b1;
            bannerPend <= '0;
            squarePend <= '0;
        end else begin
            fullPend   <= (fullPend & ~fullClr) | fullReq;
            bannerPend <= (bannerPend & ~bannerClr) | bannerReq;
            squarePend <= (squarePend & ~squareClr) | (squareReq ? (64'd1 << squareIdx) : 64'd0);
        end
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            curSel     <= REG_FULL;
            curSq      <= '0;
            scanX      <= '0;
            scanY      <= '0;
            xAddr      <= '0;
            yAddr      <= '0;
            pixelData  <= '0;
            pixelWrite <= 1'b0;
            regionDone <= 1'b0;
            lastLoaded <= 1'b0;
        end else begin
            regionDone <= doneNow;
            if (selectNow) begin
                curSel     <= nextSel;
                curSq      <= nextSq;
                scanX      <= bounds.x0;
                scanY      <= bounds.y0;
                lastLoaded <= 1'b0;
            end
            if (loadNow) begin
                xAddr      <= scanX;
                yAddr      <= scanY;
                pixelData  <= pixelIn;
                pixelWrite <= 1'b1;
                if (scanX != bounds.x1) begin
                    scanX <= scanX + 8'd1;
                end else if (scanY != bounds.y1) begin
                    scanX <= bounds.x0;
                    scanY <= scanY + 9'd1;
                end else begin
                    lastLoaded <= 1'b1;
                end
            end
            if (doneNow) pixelWrite <= 1'b0;
        end
    end

endmodule
